// File: rtl/cpu_pkg.sv
// Shared CPU encodings: opcode/funct constants, halt word and sequencer state encoding.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_SRA = 6'h03;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  localparam logic [1:0] SEQ_RUN    = 2'd0;
  localparam logic [1:0] SEQ_DRAIN  = 2'd1;
  localparam logic [1:0] SEQ_HALTED = 2'd2;

endpackage

// File: rtl/pipeline_sequencer_hazard_detect.sv
// Combinational load-use detection for the word in ID against the load in EX.
module hazard_detect
  import cpu_pkg::*;
(
  input  logic [31:0] id_instruction,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_write_reg,
  output logic        load_use,
  output logic        halt
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       rs_used;
  logic       rt_used;

  assign opcode = id_instruction[31:26];
  assign rs     = id_instruction[25:21];
  assign rt     = id_instruction[20:16];
  assign funct  = id_instruction[5:0];

  // Shift-by-shamt R-types carry a don't-care rs field.
  assign rs_used = !((opcode == OP_RTYPE) &&
                     ((funct == FN_SLL) || (funct == FN_SRL) || (funct == FN_SRA)));
  assign rt_used = (opcode == OP_RTYPE) || (opcode == OP_BEQ) ||
                   (opcode == OP_BNE)   || (opcode == OP_SW);

  assign load_use = ex_mem_read && (ex_write_reg != 5'd0) &&
                    ((rs_used && (rs == ex_write_reg)) || (rt_used && (rt == ex_write_reg)));

  assign halt = (id_instruction == HALT_WORD);

endmodule

// File: rtl/pipeline_sequencer.sv
// Pipeline sequencer: stall/flush control, halt drain FSM and performance counters.
module pipeline_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      id_instruction,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_write_reg,
  input  logic             ex_branch_taken,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             done,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] stall_count
);

  localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [DW-1:0] drain_cnt;
  logic [DW-1:0] drain_nxt;
  logic          count_en;
  logic          stall_inc;
  logic          load_use;
  logic          halt;

  hazard_detect u_hazard (
    .id_instruction (id_instruction),
    .ex_mem_read    (ex_mem_read),
    .ex_write_reg   (ex_write_reg),
    .load_use       (load_use),
    .halt           (halt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= SEQ_RUN;
      drain_cnt   <= '0;
      cycle_count <= '0;
      stall_count <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_nxt;
      if (count_en && (cycle_count != '1))
        cycle_count <= cycle_count + CNT_W'(1);
      if (stall_inc && (stall_count != '1))
        stall_count <= stall_count + CNT_W'(1);
    end
  end

  // Next state and control outputs; reset forces a safe bubble-everything pattern.
  always_comb begin
    state_nxt   = state;
    drain_nxt   = drain_cnt;
    count_en    = 1'b0;
    stall_inc   = 1'b0;
    pc_write    = 1'b0;
    if_id_write = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    done        = 1'b0;
    if (reset) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else begin
      case (state)
        SEQ_RUN: begin
          count_en = 1'b1;
          if (ex_branch_taken) begin
            // Wrong-path squash wins over any hazard or halt sitting in ID.
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (halt) begin
            id_ex_flush = 1'b1;
            state_nxt   = SEQ_DRAIN;
            drain_nxt   = DW'(DRAIN_CYCLES - 1);
          end else if (load_use) begin
            id_ex_flush = 1'b1;
            stall_inc   = 1'b1;
          end else begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
          end
        end
        SEQ_DRAIN: begin
          count_en    = 1'b1;
          id_ex_flush = 1'b1;
          if (drain_cnt == '0) state_nxt = SEQ_HALTED;
          else                 drain_nxt = drain_cnt - DW'(1);
        end
        SEQ_HALTED: begin
          id_ex_flush = 1'b1;
          done        = 1'b1;
        end
        default: begin
          id_ex_flush = 1'b1;
          state_nxt   = SEQ_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed, table-driven bench for pipeline_sequencer.
module tb_pipeline_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] id_instruction;
  logic        ex_mem_read;
  logic [4:0]  ex_write_reg;
  logic        ex_branch_taken;
  logic        pc_write;
  logic        if_id_write;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        done;
  logic [31:0] cycle_count;
  logic [31:0] stall_count;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cycles;
  int exp_stalls;

  always #5 clk = ~clk;

  pipeline_sequencer #(.DRAIN_CYCLES(4), .CNT_W(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_instruction  (id_instruction),
    .ex_mem_read     (ex_mem_read),
    .ex_write_reg    (ex_write_reg),
    .ex_branch_taken (ex_branch_taken),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .done            (done),
    .cycle_count     (cycle_count),
    .stall_count     (stall_count)
  );

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        mem_read;
    logic [4:0]  wreg;
    logic        taken;
    logic [4:0]  outs;   // {pc_write, if_id_write, if_id_flush, id_ex_flush, done}
    logic        stall;
  } vec_t;

  localparam logic [4:0] O_RESET = 5'b00110;
  localparam logic [4:0] O_RUN   = 5'b11000;
  localparam logic [4:0] O_STALL = 5'b00010;
  localparam logic [4:0] O_TAKEN = 5'b11110;
  localparam logic [4:0] O_HALT  = 5'b00011;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] instr, input logic mr, input logic [4:0] wr,
                       input logic tk);
    id_instruction  = instr;
    ex_mem_read     = mr;
    ex_write_reg    = wr;
    ex_branch_taken = tk;
  endtask

  function automatic logic [31:0] outs();
    return 32'({pc_write, if_id_write, if_id_flush, id_ex_flush, done});
  endfunction

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{"add_rs_rt_hit",   32'h0129_5020, 1'b1, 5'd9,  1'b0, O_STALL, 1'b1};
    vecs[1]  = '{"sll_rt_hit",      32'h0009_5080, 1'b1, 5'd9,  1'b0, O_STALL, 1'b1};
    vecs[2]  = '{"sll_rs_only",     32'h0120_5080, 1'b1, 5'd9,  1'b0, O_RUN,   1'b0};
    vecs[3]  = '{"lw_to_r0",        32'h0000_5020, 1'b1, 5'd0,  1'b0, O_RUN,   1'b0};
    vecs[4]  = '{"lw_rt_is_dest",   32'h8D09_0000, 1'b1, 5'd9,  1'b0, O_RUN,   1'b0};
    vecs[5]  = '{"sw_rt_hit",       32'hAD09_0000, 1'b1, 5'd9,  1'b0, O_STALL, 1'b1};
    vecs[6]  = '{"beq_rt_hit",      32'h1109_0000, 1'b1, 5'd9,  1'b0, O_STALL, 1'b1};
    vecs[7]  = '{"no_mem_read",     32'h0129_5020, 1'b0, 5'd9,  1'b0, O_RUN,   1'b0};
    vecs[8]  = '{"taken_over_halt", 32'hFFFF_FFFF, 1'b1, 5'd31, 1'b1, O_TAKEN, 1'b0};
    vecs[9]  = '{"taken_over_lu",   32'h0129_5020, 1'b1, 5'd9,  1'b1, O_TAKEN, 1'b0};
    vecs[10] = '{"bne_rs_hit",      32'h1520_0000, 1'b1, 5'd9,  1'b0, O_STALL, 1'b1};
    vecs[11] = '{"srl_miss",        32'h0009_5082, 1'b1, 5'd10, 1'b0, O_RUN,   1'b0};

    reset = 1'b1;
    drive(32'h0, 1'b0, 5'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", outs(), 32'(O_RESET));
    check("reset_cycles", cycle_count, 32'd0);
    check("reset_stalls", stall_count, 32'd0);

    // Stream of nops
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1 check("nop_outs", outs(), 32'(O_RUN));
      @(negedge clk);
    end
    check("nop_cycles", cycle_count, 32'd10);
    check("nop_stalls", stall_count, 32'd0);
    exp_cycles = 10;
    exp_stalls = 0;

    // One-cycle vectors, all evaluated in RUN
    foreach (vecs[i]) begin
      drive(vecs[i].instr, vecs[i].mem_read, vecs[i].wreg, vecs[i].taken);
      #1 check(vecs[i].name, outs(), 32'(vecs[i].outs));
      @(posedge clk);
      exp_cycles++;
      if (vecs[i].stall) exp_stalls++;
      #1;
      check({vecs[i].name, "_stalls"}, stall_count, 32'(exp_stalls));
      check({vecs[i].name, "_cycles"}, cycle_count, 32'(exp_cycles));
      @(negedge clk);
    end

    // Halt: one RUN cycle with halt in ID, then four DRAIN cycles (branch ignored)
    drive(32'hFFFF_FFFF, 1'b0, 5'd0, 1'b0);
    #1 check("halt_run_outs", outs(), 32'(O_STALL));
    @(posedge clk);
    exp_cycles++;
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      drive(32'hFFFF_FFFF, 1'b0, 5'd0, 1'b1);
      #1 check("drain_outs", outs(), 32'(O_STALL));
      @(posedge clk);
      exp_cycles++;
      @(negedge clk);
    end
    #1 check("halted_outs", outs(), 32'(O_HALT));
    check("halted_cycles", cycle_count, 32'(exp_cycles));
    check("halted_stalls", stall_count, 32'(exp_stalls));
    repeat (3) @(negedge clk);
    #1 check("halted_hold_outs", outs(), 32'(O_HALT));
    check("halted_frozen", cycle_count, 32'(exp_cycles));

    // Reset while HALTED
    #1 reset = 1'b1;
    #1 check("rst_halted_outs", outs(), 32'(O_RESET));
    check("rst_halted_cycles", cycle_count, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(32'h0, 1'b0, 5'd0, 1'b0);
    #1 check("post_rst_run", outs(), 32'(O_RUN));
    repeat (3) @(negedge clk);
    check("post_rst_cycles", cycle_count, 32'd3);

    // Halt again, then asynchronous reset mid-DRAIN between edges
    drive(32'hFFFF_FFFF, 1'b0, 5'd0, 1'b0);
    repeat (3) @(negedge clk);
    #1 check("mid_drain_outs", outs(), 32'(O_STALL));
    @(posedge clk);
    #2 reset = 1'b1;
    #1 check("async_rst_outs", outs(), 32'(O_RESET));
    check("async_rst_cycles", cycle_count, 32'd0);
    check("async_rst_stalls", stall_count, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(32'h0, 1'b0, 5'd0, 1'b0);
    #1 check("release_outs", outs(), 32'(O_RUN));
    check("release_cycles", cycle_count, 32'd0);
    @(posedge clk);
    #1 check("release_count1", cycle_count, 32'd1);
    check("release_stalls", stall_count, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
